// File: rtl/gray_pkg.sv
// Shared types and helpers for the streaming binary-to-Gray encoder.
// Contents:
//   GRAY_SIZE : default word width
//   occ_e     : skid buffer occupancy (EMPTY, ONE, TWO)
//   bin2gray  : combinational binary-to-Gray conversion at GRAY_SIZE bits
package gray_pkg;

   localparam int unsigned GRAY_SIZE = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   // MSB passes through; every lower bit is the XOR of itself and its upper neighbour.
   function automatic logic [GRAY_SIZE-1:0] bin2gray(input logic [GRAY_SIZE-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/bin2gray_stream_if.sv
// Valid/ready bundle for the binary-to-Gray encoder.
// Optional feature macro: GRAY_PARITY_EN (adds out_par).
// Signals:
//   in_valid/in_ready/in_bin     : binary input stream
//   out_valid/out_ready/out_gray : Gray output stream
//   out_par                      : parity of out_gray (GRAY_PARITY_EN only)
// Modports: slave = encoder side, master = producer/consumer side.
interface bin2gray_stream_if #(
   parameter int unsigned SIZE = 8
);
   logic            in_valid;
   logic            in_ready;
   logic [SIZE-1:0] in_bin;
   logic            out_valid;
   logic            out_ready;
   logic [SIZE-1:0] out_gray;
`ifdef GRAY_PARITY_EN
   logic            out_par;
`endif

   modport slave (
      input  in_valid,
      input  in_bin,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_gray
`ifdef GRAY_PARITY_EN
      ,
      output out_par
`endif
   );

   modport master (
      output in_valid,
      output in_bin,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_gray
`ifdef GRAY_PARITY_EN
      ,
      input  out_par
`endif
   );

endinterface

// File: rtl/gray_skid_buf.sv
// Two-entry skid buffer with an occupancy state machine. in_ready and
// out_valid are flops updated alongside the state, so neither depends
// combinationally on the handshake inputs.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload (registered)
module gray_skid_buf
   import gray_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   occ_e         state;
   logic [W-1:0] skid_q;
   logic         push;
   logic         pop;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // Occupancy FSM; out_data always holds the oldest word, skid_q the second.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_q    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  skid_q   <= in_data;
                  in_ready <= 1'b0;
                  state    <= TWO;
               end else if (push && pop) begin
                  out_data <= in_data;
               end else if (pop) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  out_data <= skid_q;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/bin2gray_stream.sv
// Streaming binary-to-Gray encoder with one cycle of latency and a
// two-entry skid buffer. Words are Gray-coded on entry, so the buffer
// only ever stores encoded values.
// Optional feature macro: GRAY_PARITY_EN (registered parity on out_par).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bin2gray_stream_if.slave (in_valid/in_ready/in_bin,
//          out_valid/out_ready/out_gray, out_par when enabled)
module bin2gray_stream
   import gray_pkg::*;
#(
   parameter int unsigned SIZE = GRAY_SIZE
) (
   input  logic                    clk,
   input  logic                    rst,
   bin2gray_stream_if.slave        bus
);

`ifdef GRAY_PARITY_EN
   localparam int unsigned W = SIZE + 1;
`else
   localparam int unsigned W = SIZE;
`endif

   logic [SIZE-1:0] gray_c;
   logic [W-1:0]    enc_c;
   logic [W-1:0]    word;

   // Package helper at its native width; other widths use the same identity inline.
   generate
      if (SIZE == GRAY_SIZE) begin : g_pkg_enc
         assign gray_c = SIZE'(bin2gray(GRAY_SIZE'(bus.in_bin)));
      end else begin : g_inline_enc
         assign gray_c = bus.in_bin ^ (bus.in_bin >> 1);
      end
   endgenerate

`ifdef GRAY_PARITY_EN
   // Parity rides in the buffer beside its word so it stalls and resets with it.
   assign enc_c       = {^gray_c, gray_c};
   assign bus.out_par = word[SIZE];
`else
   assign enc_c = gray_c;
`endif

   assign bus.out_gray = word[SIZE-1:0];

   gray_skid_buf #(
      .W (W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (enc_c),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (word)
   );

endmodule
